// File: rtl/mmc_sort_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mmc_sort_scheduler
//  Description : Samples the arm state of a modular multilevel converter on a
//                start request, holds the operands steady for an external
//                combinational capacitor-voltage sorter, and accepts the
//                returned insertion mask only if its population count equals
//                the requested insert count.
//  Ports       : clk, rst_n (sync, active-low)  - clock / reset
//                start                          - sort request pulse
//                V1..V12, I, n                  - live arm state
//                sV1..sV12, sI, sn              - latched operands to sorter
//                M_in                           - mask returned by sorter
//                gate                           - applied insertion mask
//                busy, done, err, overrun       - status
//  Options     : define MMC_SORT_HOLD_EN to add a HOLD state that enforces
//                MIN_HOLD cycles between successive gate updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmc_sort_scheduler #(
  parameter int SETTLE_CYC = 4,
  parameter int MIN_HOLD   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] V1,  input logic [31:0] V2,  input logic [31:0] V3,
  input  logic [31:0] V4,  input logic [31:0] V5,  input logic [31:0] V6,
  input  logic [31:0] V7,  input logic [31:0] V8,  input logic [31:0] V9,
  input  logic [31:0] V10, input logic [31:0] V11, input logic [31:0] V12,
  input  logic [31:0] I,
  input  logic [2:0]  n,
  output logic [31:0] sV1,  output logic [31:0] sV2,  output logic [31:0] sV3,
  output logic [31:0] sV4,  output logic [31:0] sV5,  output logic [31:0] sV6,
  output logic [31:0] sV7,  output logic [31:0] sV8,  output logic [31:0] sV9,
  output logic [31:0] sV10, output logic [31:0] sV11, output logic [31:0] sV12,
  output logic [31:0] sI,
  output logic [2:0]  sn,
  input  logic [12:1] M_in,
  output logic [12:1] gate,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        overrun
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3
`ifdef MMC_SORT_HOLD_EN
    , HOLD = 3'd4
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       pending;
  logic [3:0] popcnt;
  logic       result_ok;
  logic       leaving;     // last cycle of an operation (CHECK or end of HOLD)

  always_comb begin
    popcnt = 4'd0;
    for (int i = 1; i <= 12; i++) popcnt = popcnt + {3'd0, M_in[i]};
  end

  assign result_ok = (popcnt == {1'b0, sn});

`ifdef MMC_SORT_HOLD_EN
  localparam logic [7:0] HOLD_LAST = 8'(MIN_HOLD - 1);
  logic [7:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)              hold_cnt <= 8'd0;
    else if (state == HOLD)  hold_cnt <= hold_cnt + 8'd1;
    else                     hold_cnt <= 8'd0;
  end

  assign leaving = (state == HOLD) && (hold_cnt == HOLD_LAST);
`else
  // MIN_HOLD has no effect in this build.
  logic unused_min_hold;
  assign unused_min_hold = ^MIN_HOLD;
  assign leaving = (state == CHECK);
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = LATCH;
      LATCH:  state_nxt = SETTLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
      CHECK: begin
        done = result_ok;
        err  = !result_ok;
`ifdef MMC_SORT_HOLD_EN
        state_nxt = HOLD;
`endif
      end
`ifdef MMC_SORT_HOLD_EN
      HOLD:   state_nxt = HOLD;
`endif
      default: state_nxt = IDLE;
    endcase
    // A queued request, or one arriving right now, chains straight into the
    // next operation without passing through IDLE.
    if (leaving) state_nxt = (pending || start) ? LATCH : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      gate       <= 12'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 4'd1 : 4'd0;
      if (state == CHECK && result_ok) gate <= M_in;
      if (leaving) begin
        // Consuming the queued request; a simultaneous start re-queues.
        pending <= pending && start;
      end else if (busy && start) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sV1 <= '0; sV2 <= '0; sV3 <= '0;  sV4 <= '0;  sV5 <= '0;  sV6 <= '0;
      sV7 <= '0; sV8 <= '0; sV9 <= '0; sV10 <= '0; sV11 <= '0; sV12 <= '0;
      sI  <= '0; sn  <= '0;
    end else if (state == LATCH) begin
      sV1 <= V1; sV2 <= V2; sV3 <= V3;  sV4 <= V4;  sV5 <= V5;  sV6 <= V6;
      sV7 <= V7; sV8 <= V8; sV9 <= V9; sV10 <= V10; sV11 <= V11; sV12 <= V12;
      sI  <= I;  sn  <= n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmc_sort_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmc_sort_scheduler
//  Description : Self-checking bench for mmc_sort_scheduler. A timestamp-based
//                operation model predicts busy/done/err/gate/overrun and the
//                latched operands every cycle; vector tables and short
//                sequences cover latency, rejection, chaining and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmc_sort_scheduler;

  localparam int SC = 4;
  localparam int MH = 8;
`ifdef MMC_SORT_HOLD_EN
  localparam int HX = MH;
`else
  localparam int HX = 0;
`endif
  localparam int PERIOD = SC + 2 + HX;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] V  [1:12];
  logic [31:0] sV [1:12];
  logic [31:0] I, sI;
  logic [2:0]  n, sn;
  logic [12:1] M_in, gate;
  logic        busy, done, err, overrun;

  always #5 clk = ~clk;

  mmc_sort_scheduler #(.SETTLE_CYC(SC), .MIN_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .V1(V[1]), .V2(V[2]), .V3(V[3]), .V4(V[4]), .V5(V[5]), .V6(V[6]),
    .V7(V[7]), .V8(V[8]), .V9(V[9]), .V10(V[10]), .V11(V[11]), .V12(V[12]),
    .I(I), .n(n),
    .sV1(sV[1]), .sV2(sV[2]), .sV3(sV[3]), .sV4(sV[4]), .sV5(sV[5]), .sV6(sV[6]),
    .sV7(sV[7]), .sV8(sV[8]), .sV9(sV[9]), .sV10(sV[10]), .sV11(sV[11]), .sV12(sV[12]),
    .sI(sI), .sn(sn), .M_in(M_in), .gate(gate),
    .busy(busy), .done(done), .err(err), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  // Operation model: each operation is identified by its LATCH cycle.
  int          t;
  int          op_l;
  bit          mdl_pend, mdl_ovr;
  logic [12:1] mdl_gate;
  logic [2:0]  mdl_sn;
  logic [31:0] mdl_sv [1:12];
  logic [31:0] mdl_si;
  bit          last_done, last_err;
  int          done_t[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  task automatic model_reset();
    op_l = -100; mdl_pend = 0; mdl_ovr = 0; mdl_gate = '0; mdl_sn = '0; mdl_si = '0;
    for (int i = 1; i <= 12; i++) mdl_sv[i] = '0;
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle,
  // advance the model, then move to just after the next rising edge.
  task automatic step(input bit s, input logic [12:1] m, input bit r);
    bit act, is_c, ok;
    int last_busy;
    start = s; M_in = m; rst_n = r;
    #4;
    last_busy = op_l + SC + 1 + HX;
    act  = (t >= op_l) && (t <= last_busy);
    is_c = (t == op_l + SC + 1);
    ok   = is_c && ($countones(m) == int'(mdl_sn));
    chk("busy",    32'(busy),    32'(act));
    chk("done",    32'(done),    32'(ok));
    chk("err",     32'(err),     32'(is_c && !ok));
    chk("gate",    32'(gate),    32'(mdl_gate));
    chk("overrun", 32'(overrun), 32'(mdl_ovr));
    chk("sn",      32'(sn),      32'(mdl_sn));
    chk("sI",      sI,           mdl_si);
    for (int i = 1; i <= 12; i++) chk("sV", sV[i], mdl_sv[i]);
    last_done = done; last_err = err;
    if (done) done_t.push_back(t);
    if (!r) model_reset();
    else begin
      if (ok) mdl_gate = m;
      if (t == op_l) begin
        mdl_sn = n; mdl_si = I;
        for (int i = 1; i <= 12; i++) mdl_sv[i] = V[i];
      end
      if (act && t == last_busy) begin
        if (mdl_pend || s) begin op_l = t + 1; mdl_pend = mdl_pend && s; end
      end else if (act && s) begin
        if (mdl_pend) mdl_ovr = 1; else mdl_pend = 1;
      end else if (s) op_l = t + 1;
    end
    t++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k, input logic [12:1] m);
    for (int i = 0; i < k; i++) step(0, m, 1);
  endtask

  function automatic logic [12:1] pick_m(input logic [2:0] k);
    logic [12:1] r;
    r = '0;
    if ($urandom_range(0, 2) == 0) r = 12'($urandom);
    else while ($countones(r) < int'(k)) r[$urandom_range(1, 12)] = 1'b1;
    return r;
  endfunction

  typedef struct {
    logic [2:0]  n;
    logic [12:1] m;
    bit          exp_done;
    bit          exp_err;
    logic [12:1] exp_gate;
  } vec_t;

  vec_t vt [7];
  int   lat;

  initial begin
    vt[0] = '{3'd1, 12'h002, 1'b1, 1'b0, 12'h002};
    vt[1] = '{3'd2, 12'h007, 1'b0, 1'b1, 12'h002};
    vt[2] = '{3'd0, 12'h000, 1'b1, 1'b0, 12'h000};
    vt[3] = '{3'd7, 12'h7F0, 1'b1, 1'b0, 12'h7F0};
    vt[4] = '{3'd7, 12'hFFF, 1'b0, 1'b1, 12'h7F0};
    vt[5] = '{3'd3, 12'h881, 1'b1, 1'b0, 12'h881};
    vt[6] = '{3'd0, 12'h800, 1'b0, 1'b1, 12'h881};

    t = 0; start = 0; M_in = '0; n = '0; I = '0; rst_n = 1'b0;
    for (int i = 1; i <= 12; i++) V[i] = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_gate",    32'(gate),    32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_done",    32'(done),    32'h0);
    chk("rst_err",     32'(err),     32'h0);
    idle(2, '0);

    // Single operations from the vector table.
    for (int k = 0; k < 7; k++) begin
      n = vt[k].n;
      I = $urandom;
      for (int i = 1; i <= 12; i++) V[i] = (k == 0) ? 32'h0 : $urandom;
      if (k == 0) begin V[1] = 32'h41400000; V[9] = 32'h42F00000; end
      step(1, vt[k].m, 1);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        step(0, vt[k].m, 1);
        if (last_done || last_err) lat = c;
      end
      chk("latency",  lat,                     PERIOD - HX);
      chk("vec_done", 32'(last_done),          32'(vt[k].exp_done));
      chk("vec_err",  32'(last_err),           32'(vt[k].exp_err));
      chk("vec_gate", 32'(gate),               32'(vt[k].exp_gate));
      if (k == 0) begin
        chk("vec_sn", 32'(sn),    32'd1);
        chk("vec_sV9", sV[9],     32'h42F00000);
      end
      idle(HX + 2, '0);
    end

    // Starts during SETTLE and CHECK chain two more operations back to back.
    n = 3'd1;
    done_t.delete();
    for (int o = 0; o < 40; o++) step(o == 0 || o == 3 || o == 6, 12'h002, 1);
    chk("chain_ovr",   32'(overrun),        (HX == 0) ? 32'd0 : 32'd1);
    chk("chain_count", done_t.size(),       (HX == 0) ? 3 : 2);
    if (done_t.size() >= 2) chk("chain_gap", done_t[1] - done_t[0], PERIOD);
    else chk("chain_gap", 0, PERIOD);

    // Two starts while the first is pending -> overrun.
    for (int o = 0; o < 40; o++) step(o == 0 || o == 3 || o == 4, 12'h002, 1);
    chk("ovr_set", 32'(overrun), 32'd1);
    step(0, '0, 0);
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Continuous start: done period.
    n = 3'd2;
    done_t.delete();
    for (int o = 0; o < 4 * PERIOD + 4; o++) step(1, 12'h003, 1);
    if (done_t.size() >= 3) begin
      chk("period1", done_t[1] - done_t[0], PERIOD);
      chk("period2", done_t[2] - done_t[1], PERIOD);
    end else chk("period_cnt", done_t.size(), 3);
    idle(PERIOD + 2, 12'h003);

    // Reset in SETTLE aborts the operation and clears gate.
    n = 3'd4;
    step(1, 12'h0F0, 1);
    idle(PERIOD + 1, 12'h0F0);
    chk("pre_gate", 32'(gate), 32'h0F0);
    step(1, 12'h0F0, 1);
    idle(3, 12'h0F0);
    step(0, 12'h0F0, 0);
    chk("abort_gate", 32'(gate), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_err",  32'(err),  32'h0);
    idle(PERIOD + 2, 12'h0F0);

    // Randomized traffic against the model.
    for (int o = 0; o < 1500; o++) begin
      n = 3'($urandom);
      I = $urandom;
      for (int i = 1; i <= 12; i++) V[i] = $urandom;
      step($urandom_range(0, 3) == 0, pick_m(mdl_sn), $urandom_range(0, 399) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
